// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
//   state_e  : arbiter FSM states
//   owner_e  : which client port owns / last owned the memory
//   FetchFn3 : size code issued for every instruction fetch (word)
//   CntW     : wait-counter width, wide enough for any legal TIMEOUT
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StBusyIf,
        StBusyD,
        StResp
    } state_e;

    typedef enum logic {
        OwnerIf,
        OwnerD
    } owner_e;

    localparam logic [2:0] FetchFn3 = 3'b010;

    localparam int unsigned CntW = 16;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter between an instruction-fetch port and a data port onto a single
// shared memory port, with one transaction outstanding at a time and a wait timeout.
//
// Ports
//   clk, rst                     : clock, asynchronous active-high reset
//   if_req/if_addr               : fetch request, held until if_gnt
//   if_gnt/if_rvalid/if_rdata/if_err : fetch grant pulse, response pulse, data, timeout flag
//   d_req/d_we/d_addr/d_wdata/d_fn3  : data request, held until d_gnt
//   d_gnt/d_rvalid/d_rdata/d_err     : data grant pulse, response pulse, data, timeout flag
//   m_req/m_we/m_addr/m_wdata/m_fn3  : shared memory request (valid only while busy)
//   m_ack/m_rdata                : memory completion pulse and read data
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_err,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    input  logic [2:0]        d_fn3,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,

    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output logic [2:0]        m_fn3,
    input  logic              m_ack,
    input  logic [DATA_W-1:0] m_rdata
);

    localparam logic [CntW-1:0] TimeoutCnt = CntW'(TIMEOUT);

    state_e            state_q, state_d;
    owner_e            last_grant_q, last_grant_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0] req_addr_q, req_addr_d;
    logic              req_we_q, req_we_d;
    logic [DATA_W-1:0] req_wdata_q, req_wdata_d;
    logic [2:0]        req_fn3_q, req_fn3_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              err_q, err_d;

    logic grant_if, grant_d;
    logic busy;

    assign busy = (state_q == StBusyIf) || (state_q == StBusyD);

    // Grants are combinational in IDLE only; suppressed while reset is held.
    always_comb begin
        grant_if = 1'b0;
        grant_d  = 1'b0;
        if (state_q == StIdle && !rst) begin
            if (if_req && d_req) begin
                grant_d  = (last_grant_q == OwnerIf);
                grant_if = !grant_d;
            end else begin
                grant_if = if_req;
                grant_d  = d_req;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        req_addr_d   = req_addr_q;
        req_we_d     = req_we_q;
        req_wdata_d  = req_wdata_q;
        req_fn3_d    = req_fn3_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;
        err_d        = err_q;

        unique case (state_q)
            StIdle: begin
                if (grant_if) begin
                    state_d      = StBusyIf;
                    last_grant_d = OwnerIf;
                    cnt_d        = '0;
                    req_addr_d   = if_addr;
                    req_we_d     = 1'b0;
                    req_wdata_d  = '0;
                    req_fn3_d    = FetchFn3;
                end else if (grant_d) begin
                    state_d      = StBusyD;
                    last_grant_d = OwnerD;
                    cnt_d        = '0;
                    req_addr_d   = d_addr;
                    req_we_d     = d_we;
                    req_wdata_d  = d_wdata;
                    req_fn3_d    = d_fn3;
                end
            end
            StBusyIf, StBusyD: begin
                // An ack wins even in the cycle the counter has reached TIMEOUT.
                if (m_ack) begin
                    state_d = StResp;
                    err_d   = 1'b0;
                    if (state_q == StBusyIf) begin
                        if_rdata_d = m_rdata;
                    end else begin
                        d_rdata_d = m_rdata;
                    end
                end else if (cnt_q == TimeoutCnt) begin
                    state_d = StResp;
                    err_d   = 1'b1;
                    if (state_q == StBusyIf) begin
                        if_rdata_d = '0;
                    end else begin
                        d_rdata_d = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= OwnerIf;
            cnt_q        <= '0;
            req_addr_q   <= '0;
            req_we_q     <= 1'b0;
            req_wdata_q  <= '0;
            req_fn3_q    <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            req_addr_q   <= req_addr_d;
            req_we_q     <= req_we_d;
            req_wdata_q  <= req_wdata_d;
            req_fn3_q    <= req_fn3_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
            err_q        <= err_d;
        end
    end

    // In RESP the owner is the most recent grantee.
    always_comb begin
        if_gnt    = grant_if;
        d_gnt     = grant_d;
        if_rvalid = (state_q == StResp) && (last_grant_q == OwnerIf);
        d_rvalid  = (state_q == StResp) && (last_grant_q == OwnerD);
        if_err    = if_rvalid && err_q;
        d_err     = d_rvalid && err_q;
        if_rdata  = if_rdata_q;
        d_rdata   = d_rdata_q;
        m_req     = busy;
        m_we      = busy ? req_we_q : 1'b0;
        m_addr    = busy ? req_addr_q : '0;
        m_wdata   = busy ? req_wdata_q : '0;
        m_fn3     = busy ? req_fn3_q : 3'b000;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid, if_err;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid, d_err;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [2:0]  d_fn3;
    logic        m_req, m_we, m_ack;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [2:0]  m_fn3;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: last winner (0 = fetch, 1 = data) and expected read data.
    bit          last_win;
    bit          if_known, d_known;
    logic [31:0] exp_if_rd, exp_d_rd;

    mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(TMO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_gnt   (if_gnt),
        .if_rvalid(if_rvalid),
        .if_rdata (if_rdata),
        .if_err   (if_err),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_fn3    (d_fn3),
        .d_gnt    (d_gnt),
        .d_rvalid (d_rvalid),
        .d_rdata  (d_rdata),
        .d_err    (d_err),
        .m_req    (m_req),
        .m_we     (m_we),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_fn3    (m_fn3),
        .m_ack    (m_ack),
        .m_rdata  (m_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic check_held();
        if (if_known) check_eq("if_rdata_hold", 64'(if_rdata), 64'(exp_if_rd));
        if (d_known)  check_eq("d_rdata_hold", 64'(d_rdata), 64'(exp_d_rd));
    endtask

    // One complete transaction: grant cycle, busy cycles, RESP, one idle cycle.
    // n_ack = cycles from grant to m_ack; beyond TMO+1 the ack never comes.
    task automatic run_txn(input bit rq_if, input bit rq_d, input logic [31:0] ia,
                           input logic [31:0] da, input logic [31:0] dw, input logic dwe,
                           input logic [2:0] dfn3, input int n_ack, input logic [31:0] rd);
        bit          win_d, tmo;
        int          busy_len;
        logic [31:0] e_addr;
        logic        e_we;
        logic [2:0]  e_fn3;

        win_d    = rq_d && (!rq_if || !last_win);
        tmo      = (n_ack > TMO + 1);
        busy_len = tmo ? TMO + 1 : n_ack;
        e_addr   = win_d ? da : ia;
        e_we     = win_d ? dwe : 1'b0;
        e_fn3    = win_d ? dfn3 : 3'b010;

        @(posedge clk); #2;
        if_req = rq_if; if_addr = ia;
        d_req = rq_d; d_addr = da; d_wdata = dw; d_we = dwe; d_fn3 = dfn3;
        m_ack = 1'b0;
        #1;
        check_eq("if_gnt", 64'(if_gnt), 64'(!win_d));
        check_eq("d_gnt", 64'(d_gnt), 64'(win_d));
        last_win = win_d;

        for (int k = 1; k <= busy_len; k++) begin
            @(posedge clk); #2;
            if_req = 1'b0; d_req = 1'b0;
            if_addr = $urandom; d_addr = $urandom; d_wdata = $urandom; d_we = 1'($urandom);
            m_ack   = (k == n_ack);
            m_rdata = (k == n_ack) ? rd : $urandom;
            #1;
            check_eq("busy_m_ctl", 64'({m_req, m_we, m_fn3}), 64'({1'b1, e_we, e_fn3}));
            check_eq("busy_m_addr", 64'(m_addr), 64'(e_addr));
            if (win_d) check_eq("busy_m_wdata", 64'(m_wdata), 64'(dw));
            check_eq("busy_rsp", 64'({if_rvalid, if_err, d_rvalid, d_err}), 64'(0));
            check_eq("busy_gnt", 64'({if_gnt, d_gnt}), 64'(0));
        end

        // RESP: requests presented here must not be granted; stray ack ignored.
        @(posedge clk); #2;
        if_req = 1'b1; d_req = 1'b1;
        m_ack = 1'($urandom); m_rdata = $urandom;
        #1;
        check_eq("resp_gnt", 64'({if_gnt, d_gnt}), 64'(0));
        check_eq("resp_m_ctl", 64'({m_req, m_we, m_fn3}), 64'(0));
        check_eq("resp_m_bus", {m_addr, m_wdata}, 64'(0));
        check_eq("resp_if_rvalid", 64'(if_rvalid), 64'(!win_d));
        check_eq("resp_d_rvalid", 64'(d_rvalid), 64'(win_d));
        check_eq("resp_err", 64'(win_d ? d_err : if_err), 64'(tmo));
        check_eq("resp_other_err", 64'(win_d ? if_err : d_err), 64'(0));
        if (win_d) begin
            if (tmo || !dwe) begin
                exp_d_rd = tmo ? 32'h0 : rd;
                d_known  = 1'b1;
                check_eq("resp_d_rdata", 64'(d_rdata), 64'(exp_d_rd));
            end else begin
                d_known = 1'b0;
            end
            if (if_known) check_eq("if_rdata_hold", 64'(if_rdata), 64'(exp_if_rd));
        end else begin
            exp_if_rd = tmo ? 32'h0 : rd;
            if_known  = 1'b1;
            check_eq("resp_if_rdata", 64'(if_rdata), 64'(exp_if_rd));
            if (d_known) check_eq("d_rdata_hold", 64'(d_rdata), 64'(exp_d_rd));
        end

        // Idle cycle with no requests; a stray ack here must be ignored.
        @(posedge clk); #2;
        if_req = 1'b0; d_req = 1'b0;
        m_ack = 1'($urandom); m_rdata = $urandom;
        #1;
        check_eq("idle_out", 64'({if_gnt, d_gnt, if_rvalid, d_rvalid, m_req, m_we}), 64'(0));
        check_held();
        @(posedge clk); #2;
        m_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        if_req = 1'b1; if_addr = 32'h1234; d_req = 1'b1; d_we = 1'b1;
        d_addr = 32'h55; d_wdata = 32'h66; d_fn3 = 3'b001;
        m_ack = 1'b1; m_rdata = 32'hFFFF_FFFF;
        last_win = 1'b0;
        if_known = 1'b1; d_known = 1'b1;
        exp_if_rd = 32'h0; exp_d_rd = 32'h0;

        // Reset values, with every input active.
        repeat (2) @(posedge clk);
        #3;
        check_eq("rst_gnt", 64'({if_gnt, d_gnt}), 64'(0));
        check_eq("rst_rsp", 64'({if_rvalid, if_err, d_rvalid, d_err}), 64'(0));
        check_eq("rst_m_ctl", 64'({m_req, m_we, m_fn3}), 64'(0));
        check_eq("rst_m_bus", {m_addr, m_wdata}, 64'(0));
        check_eq("rst_rdata", {if_rdata, d_rdata}, 64'(0));
        @(posedge clk); #2;
        rst = 1'b0; if_req = 1'b0; d_req = 1'b0; m_ack = 1'b0;

        // Fetch, ack two cycles after grant.
        run_txn(1, 0, 32'h8000_0000, 32'h0, 32'h0, 1'b0, 3'b010, 2, 32'h0000_0013);

        // Three conflicts: data, fetch, data.
        run_txn(1, 1, 32'h0000_0040, 32'h0000_0200, 32'h0, 1'b0, 3'b100, 1, 32'hA5A5_0001);
        run_txn(1, 1, 32'h0000_0044, 32'h0000_0204, 32'h0, 1'b0, 3'b000, 1, 32'hA5A5_0002);
        run_txn(1, 1, 32'h0000_0048, 32'h0000_0208, 32'h0, 1'b0, 3'b101, 3, 32'hA5A5_0003);

        // Data write.
        run_txn(0, 1, 32'h0, 32'h0000_0100, 32'hDEAD_BEEF, 1'b1, 3'b010, 3, 32'h0);

        // Timeout then a normal request; then ack exactly at the timeout cycle.
        run_txn(0, 1, 32'h0, 32'h0000_0300, 32'h0, 1'b0, 3'b010, TMO + 2, 32'h0);
        run_txn(0, 1, 32'h0, 32'h0000_0304, 32'h0, 1'b0, 3'b010, 2, 32'h1111_2222);
        run_txn(0, 1, 32'h0, 32'h0000_0308, 32'h0, 1'b0, 3'b010, TMO + 1, 32'h3333_4444);
        run_txn(1, 0, 32'h0000_0400, 32'h0, 32'h0, 1'b0, 3'b010, TMO + 3, 32'h0);

        // Reset during a data transaction, then a stray ack after release.
        @(posedge clk); #2;
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0500; d_fn3 = 3'b010;
        #1;
        check_eq("rst_mid_gnt", 64'(d_gnt), 64'(1));
        @(posedge clk); #2;
        d_req = 1'b0;
        #1;
        check_eq("rst_mid_busy", 64'(m_req), 64'(1));
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_out", 64'({m_req, m_we, if_rvalid, d_rvalid, if_err, d_err}), 64'(0));
        check_eq("rst_mid_rdata", {if_rdata, d_rdata}, 64'(0));
        @(posedge clk); #2;
        rst = 1'b0; m_ack = 1'b1; m_rdata = 32'hBAD0_BAD0;
        #1;
        check_eq("stray_ack_a", 64'({m_req, if_rvalid, d_rvalid}), 64'(0));
        @(posedge clk); #2;
        m_ack = 1'b0;
        #1;
        check_eq("stray_ack_b", 64'({m_req, if_rvalid, d_rvalid}), 64'(0));
        check_eq("stray_ack_rdata", {if_rdata, d_rdata}, 64'(0));
        last_win = 1'b0;
        if_known = 1'b1; d_known = 1'b1; exp_if_rd = 32'h0; exp_d_rd = 32'h0;

        // After reset the first conflict goes to data again.
        run_txn(1, 1, 32'h0000_0600, 32'h0000_0700, 32'h0, 1'b0, 3'b010, 2, 32'h7777_8888);

        // Randomized traffic.
        for (int t = 0; t < 150; t++) begin
            int unsigned pat;
            pat = $urandom_range(1, 3);
            run_txn(pat[0], pat[1], $urandom, $urandom, $urandom, 1'($urandom),
                    3'($urandom), int'($urandom_range(1, TMO + 3)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
